// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard VESA mode segment values and a line/frame total helper.
package vga_timing_pkg;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP = 33;
  localparam bit VGA640_H_POL = 1'b0;
  localparam bit VGA640_V_POL = 1'b0;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP = 40;
  localparam int SVGA800_H_SYNC = 128;
  localparam int SVGA800_H_BP = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP = 1;
  localparam int SVGA800_V_SYNC = 4;
  localparam int SVGA800_V_BP = 23;
  localparam bit SVGA800_H_POL = 1'b1;
  localparam bit SVGA800_V_POL = 1'b1;

  localparam int XGA1024_H_ACTIVE = 1024;
  localparam int XGA1024_H_FP = 24;
  localparam int XGA1024_H_SYNC = 136;
  localparam int XGA1024_H_BP = 160;
  localparam int XGA1024_V_ACTIVE = 768;
  localparam int XGA1024_V_FP = 3;
  localparam int XGA1024_V_SYNC = 6;
  localparam int XGA1024_V_BP = 29;
  localparam bit XGA1024_H_POL = 1'b0;
  localparam bit XGA1024_V_POL = 1'b0;

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: video timing bus from the generator to the draw pipeline.
// frame_cnt is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if #(
  parameter int CNT_W = 11,
  parameter int FRAME_CNT_W = 8
);
  import vga_timing_pkg::*;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic hblnk;
  logic vblnk;
  logic hsync;
  logic vsync;
  logic de;
  logic line_start;
  logic frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
  modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start, frame_cnt);
  modport slave (input hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start, frame_cnt);
`else
  modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start);
  modport slave (input hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one timing axis; count/blnk/sync are registered from the next count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W = 11,
  parameter int ACTIVE = 800,
  parameter int FP = 40,
  parameter int SYNC = 128,
  parameter int BP = 88,
  parameter logic POL = 1'b1
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap,
  output logic             blnk_nxt
);
  localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] S_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(ACTIVE + FP + SYNC);
  generate
    if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0 || TOTAL >= (1 << CNT_W)) begin : g_bad_cfg
      $error("vga_axis_counter: zero segment or total does not fit CNT_W");
    end
  endgenerate
  logic [CNT_W-1:0] count_nxt;
  logic sync_nxt;
  always_comb begin
    wrap = count == LAST;
    count_nxt = wrap ? '0 : count + 1'b1;
    blnk_nxt = count_nxt >= CNT_W'(ACTIVE);
    sync_nxt = (count_nxt >= S_BEG && count_nxt < S_END) ? POL : ~POL;
  end
  // Reset parks on the last count, which always lies in the back porch.
  always_ff @(posedge pclk) begin
    if (reset) begin
      count <= LAST;
      blnk <= 1'b1;
      sync <= ~POL;
    end else if (adv) begin
      count <= count_nxt;
      blnk <= blnk_nxt;
      sync <= sync_nxt;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/VESA timing generator with pixel-enable stall.
// Define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP = 23,
  parameter logic H_POL = 1'b1,
  parameter logic V_POL = 1'b1,
  parameter int FRAME_CNT_W = 8
) (
  input  logic pclk,
  input  logic reset,
  input  logic en,
  vga_timing_if.master vid
);
  generate
    if (FRAME_CNT_W < 1) begin : g_bad_fcw
      $error("vga_timing_gen: FRAME_CNT_W must be at least 1");
    end
  endgenerate
  logic [CNT_W-1:0] hcount, vcount;
  logic h_blnk, v_blnk, h_sync, v_sync;
  logic h_wrap, v_wrap, h_blnk_nxt, v_blnk_nxt;
  logic de, line_start, frame_start;
  vga_axis_counter #(
    .CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_h (
    .pclk(pclk), .reset(reset), .adv(en), .count(hcount), .blnk(h_blnk),
    .sync(h_sync), .wrap(h_wrap), .blnk_nxt(h_blnk_nxt)
  );
  vga_axis_counter #(
    .CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_v (
    .pclk(pclk), .reset(reset), .adv(en & h_wrap), .count(vcount), .blnk(v_blnk),
    .sync(v_sync), .wrap(v_wrap), .blnk_nxt(v_blnk_nxt)
  );
  // The vertical axis only moves when the line wraps, so pick its next blank accordingly.
  always_ff @(posedge pclk) begin
    if (reset) begin
      de <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start <= en & h_wrap;
      frame_start <= en & h_wrap & v_wrap;
      if (en) de <= ~h_blnk_nxt & ~(h_wrap ? v_blnk_nxt : v_blnk);
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic seen;
  // The first frame after reset is frame 0; later frame starts count up.
  always_ff @(posedge pclk) begin
    if (reset) begin
      frame_cnt <= '0;
      seen <= 1'b0;
    end else if (en & h_wrap & v_wrap) begin
      seen <= 1'b1;
      if (seen) frame_cnt <= frame_cnt + 1'b1;
    end
  end
  assign vid.frame_cnt = frame_cnt;
`endif
  assign vid.hcount = hcount;
  assign vid.vcount = vcount;
  assign vid.hblnk = h_blnk;
  assign vid.vblnk = v_blnk;
  assign vid.hsync = h_sync;
  assign vid.vsync = v_sync;
  assign vid.de = de;
  assign vid.line_start = line_start;
  assign vid.frame_start = frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of an 800-wide active-high mode and a tiny active-low mode.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;
  logic pclk = 1'b0;
  logic rst_a = 1'b1, en_a = 1'b1, rst_b = 1'b1, en_b = 1'b1;
  int total = 0, bad = 0;
  always #5 pclk = ~pclk;

  vga_timing_if #(.CNT_W(11), .FRAME_CNT_W(8)) ia ();
  vga_timing_if #(.CNT_W(11), .FRAME_CNT_W(8)) ib ();

  vga_timing_gen #(
    .CNT_W(11), .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC),
    .H_BP(SVGA800_H_BP), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b1), .FRAME_CNT_W(8)
  ) dut_a (.pclk(pclk), .reset(rst_a), .en(en_a), .vid(ia));

  vga_timing_gen #(
    .CNT_W(11), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .FRAME_CNT_W(8)
  ) dut_b (.pclk(pclk), .reset(rst_b), .en(en_b), .vid(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_a(input int h, input int v);
    int found = 0;
    for (int i = 0; i < 20000 && found == 0; i++) begin
      step();
      if (ia.hcount == 11'(h) && ia.vcount == 11'(v)) found = 1;
    end
    chk("a_reach_pos", found, 1);
  endtask

  initial begin
    int ls_gap, period, hbl_rise, hs_first, hs_last, hs_cnt;
    int vbl_rise, vs_first, vs_last, vs_cnt, vs_rise_h, de_err, frz_err, fs_n;
    logic [31:0] snap;
    step();
    step();
    // A in reset
    chk("a_rst_hcount", ia.hcount, 1055);
    chk("a_rst_vcount", ia.vcount, 11);
    chk("a_rst_blnk", {ia.hblnk, ia.vblnk}, 2'b11);
    chk("a_rst_sync", {ia.hsync, ia.vsync}, 2'b00);
    chk("a_rst_strobes", {ia.de, ia.line_start, ia.frame_start}, 3'b000);
    chk("b_rst_sync", {ib.hsync, ib.vsync}, 2'b11);
    rst_a = 1'b0;
    step();
    chk("a_first_pos", {21'd0, ia.hcount, ia.vcount}, 0);
    chk("a_first_flags", {ia.de, ia.line_start, ia.frame_start, ia.hblnk, ia.vblnk}, 5'b11100);
    // scan one whole frame of A
    ls_gap = -1; period = -1; hbl_rise = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
    vbl_rise = -1; vs_first = -1; vs_last = -1; vs_cnt = 0; vs_rise_h = -1; de_err = 0;
    for (int i = 1; i <= 13000 && period < 0; i++) begin
      step();
      if (ia.frame_start) period = i;
      if (ia.line_start && ls_gap < 0) ls_gap = i;
      if (ia.vcount == 0 && ia.hblnk && hbl_rise < 0) hbl_rise = int'(ia.hcount);
      if (ia.vcount == 0 && ia.hsync) begin
        if (hs_first < 0) hs_first = int'(ia.hcount);
        hs_last = int'(ia.hcount);
        hs_cnt++;
      end
      if (ia.vblnk && vbl_rise < 0) vbl_rise = int'(ia.vcount);
      if (ia.vsync) begin
        if (vs_first < 0) begin
          vs_first = int'(ia.vcount);
          vs_rise_h = int'(ia.hcount);
        end
        vs_last = int'(ia.vcount);
        vs_cnt++;
      end
      if (ia.de !== (ia.hcount < 800 && ia.vcount < 6)) de_err++;
    end
    chk("a_line_period", ls_gap, 1056);
    chk("a_hblnk_rise", hbl_rise, 800);
    chk("a_hsync_first", hs_first, 840);
    chk("a_hsync_last", hs_last, 967);
    chk("a_hsync_width", hs_cnt, 128);
    chk("a_vblnk_rise", vbl_rise, 6);
    chk("a_vsync_first", vs_first, 7);
    chk("a_vsync_last", vs_last, 8);
    chk("a_vsync_at_h0", vs_rise_h, 0);
    chk("a_vsync_cycles", vs_cnt, 2112);
    chk("a_frame_period", period, 12672);
    chk("a_de_errors", de_err, 0);
    // stall in the middle of a line
    wait_a(500, 3);
    snap = {ia.hcount, ia.vcount, ia.hblnk, ia.vblnk, ia.hsync, ia.vsync, ia.de, 5'b0};
    en_a = 1'b0;
    frz_err = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if ({ia.hcount, ia.vcount, ia.hblnk, ia.vblnk, ia.hsync, ia.vsync, ia.de, 5'b0} !== snap) frz_err++;
      if (ia.line_start || ia.frame_start) frz_err++;
    end
    chk("a_stall_frozen", frz_err, 0);
    en_a = 1'b1;
    step();
    chk("a_after_stall_h", ia.hcount, 501);
    chk("a_after_stall_v", ia.vcount, 3);
    // stall right on a line_start strobe
    wait_a(0, 4);
    chk("a_ls_before_stall", ia.line_start, 1);
    en_a = 1'b0;
    step();
    chk("a_ls_in_stall", {ia.line_start, ia.hcount}, 0);
    en_a = 1'b1;
    // reset beats en=0
    wait_a(300, 4);
    rst_a = 1'b1;
    en_a = 1'b0;
    step();
    chk("a_midrst_pos", {10'd0, ia.hcount, ia.vcount}, {10'd0, 11'd1055, 11'd11});
    chk("a_midrst_flags", {ia.hblnk, ia.vblnk, ia.hsync, ia.vsync, ia.de}, 5'b11000);
    rst_a = 1'b0;
    en_a = 1'b1;
    step();
    chk("a_restart_fs", {ia.frame_start, ia.line_start, ia.de, ia.hcount, ia.vcount}, {3'b111, 22'd0});

    // B: active-low syncs, tiny mode
    rst_b = 1'b0;
    step();
    chk("b_first", {ib.frame_start, ib.hsync, ib.vsync, ib.hcount, ib.vcount}, {3'b111, 22'd0});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_fcnt_first", ib.frame_cnt, 0);
`endif
    period = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; vs_first = -1; vs_last = -1; vs_cnt = 0;
    for (int i = 1; i <= 200 && period < 0; i++) begin
      step();
      if (ib.frame_start) period = i;
      if (!ib.hsync) begin
        if (hs_first < 0) hs_first = int'(ib.hcount);
        hs_last = int'(ib.hcount);
        hs_cnt++;
      end
      if (!ib.vsync) begin
        if (vs_first < 0) vs_first = int'(ib.vcount);
        vs_last = int'(ib.vcount);
        vs_cnt++;
      end
    end
    chk("b_frame_period", period, 120);
    chk("b_hsync_lo_first", hs_first, 10);
    chk("b_hsync_lo_last", hs_last, 12);
    chk("b_hsync_lo_cycles", hs_cnt, 24);
    chk("b_vsync_lo_first", vs_first, 5);
    chk("b_vsync_lo_last", vs_last, 6);
    chk("b_vsync_lo_cycles", vs_cnt, 30);
    for (int i = 0; i < 50; i++) step();
    rst_b = 1'b1;
    step();
    chk("b_midrst", {ib.hsync, ib.vsync, ib.de, ib.hcount, ib.vcount}, {3'b110, 11'd14, 11'd7});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_fcnt_rst", ib.frame_cnt, 0);
`endif
    rst_b = 1'b0;
    step();
    chk("b_restart_fs", ib.frame_start, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_fcnt_restart", ib.frame_cnt, 0);
    fs_n = 1;
    for (int i = 0; i < 40000 && fs_n < 257; i++) begin
      step();
      if (ib.frame_start) begin
        fs_n++;
        if (fs_n == 2) chk("b_fcnt_2", ib.frame_cnt, 1);
        if (fs_n == 256) chk("b_fcnt_256", ib.frame_cnt, 255);
        if (fs_n == 257) chk("b_fcnt_wrap", ib.frame_cnt, 0);
      end
    end
    chk("b_fs_count", fs_n, 257);
`else
    fs_n = 1;
    chk("b_fs_count", fs_n + {31'd0, ib.frame_start}, 2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/VESA video timing generator for any mode defined by its porch, sync and active values. Produces horizontal and vertical counters, blanking, polarity-configurable syncs, a data-enable and start-of-line/frame strobes. Supports a pixel-enable stall input. Sits between the pclk domain clock source and the downstream draw/overlay pipeline.

Parameters:
CNT_W, 11, width of hcount/vcount
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
H_POL, 1, hsync active level (1 = active-high)
V_POL, 1, vsync active level
FRAME_CNT_W, 8, frame counter width (optional feature only)

Ports:
pclk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
en  in  1  pixel advance enable; low = hold all state
hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1
vcount  out  CNT_W  vertical position, 0..V_TOTAL-1
hblnk  out  1  high when hcount >= H_ACTIVE
vblnk  out  1  high when vcount >= V_ACTIVE
hsync  out  1  horizontal sync at H_POL level when active
vsync  out  1  vertical sync at V_POL level when active
de  out  1  ~hblnk & ~vblnk
line_start  out  1  one-cycle strobe when hcount becomes 0
frame_start  out  1  one-cycle strobe when hcount and vcount both become 0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock pclk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if any parameter is 0 or either total >= 2**CNT_W.
- All outputs are registered. Each output is computed from the next counter values, so every output is consistent with the hcount/vcount shown in the same cycle (zero relative latency).
- Reset: hcount=H_TOTAL-1, vcount=V_TOTAL-1 (last pixel of frame), hblnk=1, vblnk=1, hsync=~H_POL, vsync=~V_POL, de=0, line_start=0, frame_start=0. The first enabled edge after reset presents (0,0) with de=1, line_start=1 and frame_start=1.
- Enabled edge: hcount increments. At H_TOTAL-1, hcount wraps to 0 and vcount increments. vcount wraps to 0 at V_TOTAL-1 when hcount wraps.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync is active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes only together with the vcount change, i.e. aligned to hcount=0.
- en=0: counters, hblnk, vblnk, hsync, vsync and de hold their values. line_start and frame_start are forced to 0, so a strobe never repeats across a stall.
- Reset asserted mid-frame takes priority over en. Outputs show reset values on the next cycle, regardless of position.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds output frame_cnt [FRAME_CNT_W-1:0], reset 0. It increments in the same cycle frame_start asserts, after the first frame: the first frame_start after reset leaves frame_cnt at 0, and each later one adds 1. Wraps from 2**FRAME_CNT_W-1 to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg: localparam sets for 640x480@60, 800x600@60 and 1024x768@60 (active/fp/sync/bp/polarity), and a function returning the total from the four segment values.
- Sub-module vga_axis_counter: generic per-axis counter with inputs adv and params ACTIVE/FP/SYNC/BP/POL, and outputs count, blnk, sync, wrap.
  - Horizontal instance: adv = en.
  - Vertical instance: adv = en & h_wrap.
- The top level derives de, line_start and frame_start.

Test Plan:
- Reset release with defaults, en=1 -> first cycle hcount=0, vcount=0, de=1, line_start=1, frame_start=1; hsync=0 and vsync=0 during reset.
- Default mode, one line -> hblnk rises at hcount=800; hsync=1 for hcount 840..967; line_start period of 1056 cycles.
- Default mode, full frame -> vblnk=1 for vcount 600..627; vsync=1 for vcount 601..604 (4224 cycles); frame_start period of 663168 cycles.
- en=0 for 7 cycles at hcount=500, vcount=10 -> all outputs frozen, no strobes; the next enabled edge gives hcount=501.
- 640x480 params (640/16/96/48, 480/10/2/33), H_POL=V_POL=0 -> hsync=0 only for hcount 656..751; vsync=0 only for vcount 490..491; both are 1 in reset.
- Reset pulse at hcount=300, vcount=200 -> next cycle at reset values; restart gives frame_start=1. With VGA_TIMING_FRAME_CNT_EN, frame_cnt=0 after the restart, and after 257 frame_starts from reset it has wrapped 255->0.
